// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared constants for the seven-segment console: digit count,
//            blank pattern and active-low hex glyph table (g..a).
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int c_NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index n holds the active-low glyph for hex digit n, bit order g,f,e,d,c,b,a.
    localparam logic [15:0][6:0] c_HEX7 = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex7(input logic [3:0] n);
        return c_HEX7[n];
    endfunction

endpackage
`default_nettype wire

// File: rtl/go_debounce.sv
`default_nettype none
// ============================================================================
// Module   : go_debounce
// Purpose  : Two-flop synchronizer, stable-level debouncer and rising-edge
//            detector for the raw GO push-button.
// Revision : 1.0 - initial release
// ============================================================================
module go_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic CLR,
    input  logic i_btn,
    output logic o_st,
    output logic o_rise
);

    localparam int c_DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DC_MAX = c_DW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_st;
    logic            r_st_d;
    logic [c_DW-1:0] r_dc;

    // Synchronize the button, then accept a new level only after it has
    // differed from the stable level for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_st    <= 1'b0;
            r_st_d  <= 1'b0;
            r_dc    <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_st_d  <= r_st;
            if (r_sync2 == r_st) begin
                r_dc <= '0;
            end else if (r_dc == c_DC_MAX) begin
                r_st <= r_sync2;
                r_dc <= '0;
            end else begin
                r_dc <= r_dc + 1'b1;
            end
        end
    end

    assign o_st   = r_st;
    assign o_rise = r_st & ~r_st_d;

endmodule
`default_nettype wire

// File: rtl/seg_console.sv
`default_nettype none
// ============================================================================
// Module   : seg_console
// Purpose  : Latches syscall print values, scans them as eight hex digits on
//            an active-low multiplexed seven-segment display (dp = halt), and
//            returns a debounced GO pulse to the syscall controller while the
//            CPU is halted.
// Revision : 1.0 - initial release
// ============================================================================
module seg_console
    import seg_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    print_en,
    input  logic [31:0]             print_data,
    input  logic                    halt,
    input  logic                    go_btn,
    output logic                    go_pulse,
    output logic [31:0]             shown,
    output logic [6:0]              seg,
    output logic [c_NUM_DIGITS-1:0] an,
    output logic                    dp
);

    localparam int c_CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IW = $clog2(c_NUM_DIGITS);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(SCAN_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic [c_IW-1:0] r_idx;
    logic            w_btn_st;
    logic            w_btn_rise;

    // Capture the value of each print syscall; the last strobe wins.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            shown <= '0;
        end else if (print_en) begin
            shown <= print_data;
        end
    end

    // Dwell SCAN_DIV cycles on each digit, then advance to the next (mod 8).
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Register the anode, glyph and halt dot for the digit currently selected.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(c_NUM_DIGITS'(1) << r_idx);
            seg <= hex7(shown[{r_idx, 2'b00} +: 4]);
            dp  <= ~(halt && (r_idx == '0));
        end
    end

    go_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .CLK   (CLK),
        .CLR   (CLR),
        .i_btn (go_btn),
        .o_st  (w_btn_st),
        .o_rise(w_btn_rise)
    );

    // A press counts only if the CPU is halted in the cycle after acceptance;
    // otherwise it is dropped rather than held for a later halt.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            go_pulse <= 1'b0;
        end else begin
            go_pulse <= w_btn_rise && w_btn_st && halt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_console
// Purpose  : Self-checking bench for seg_console: directed scenarios plus a
//            randomized phase, all compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_console;

    localparam int SCAN_DIV = 4;
    localparam int DC       = 8;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        print_en;
    logic [31:0] print_data;
    logic        halt;
    logic        go_btn;
    logic        go_pulse;
    logic [31:0] shown;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;

    seg_console #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .print_en  (print_en),
        .print_data(print_data),
        .halt      (halt),
        .go_btn    (go_btn),
        .go_pulse  (go_pulse),
        .shown     (shown),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model: display position derived from elapsed cycles since
    // reset; button modelled as a 2-sample delay and a mismatch run length.
    logic [31:0] m_shown = '0;
    int          m_t     = 0;
    logic        m_s1 = 1'b0, m_s2 = 1'b0, m_st = 1'b0, m_rose = 1'b0;
    int          m_run   = 0;
    logic [7:0]  exp_an  = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp  = 1'b1;
    logic        exp_go  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, update the model with the inputs that edge saw,
    // and compare every output.
    task automatic step();
        logic        c_clr, c_pen, c_halt, c_btn;
        logic [31:0] c_pdata;
        int          idx;
        c_clr = CLR; c_pen = print_en; c_pdata = print_data; c_halt = halt; c_btn = go_btn;
        @(posedge CLK);
        #1;
        if (c_clr) begin
            m_shown = '0; m_t = 0; m_s1 = 0; m_s2 = 0; m_st = 0; m_run = 0; m_rose = 0;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_go = 1'b0;
        end else begin
            idx     = (m_t / SCAN_DIV) % 8;
            exp_an  = ~(8'h01 << idx);
            exp_seg = hex_tab[m_shown[4*idx +: 4]];
            exp_dp  = ~(c_halt && (idx == 0));
            m_t++;
            exp_go  = m_rose && c_halt;
            m_rose  = 1'b0;
            if (m_s2 != m_st) begin
                m_run++;
                if (m_run == DC) begin
                    m_st   = m_s2;
                    m_run  = 0;
                    m_rose = m_st;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = c_btn;
            if (c_pen) m_shown = c_pdata;
        end
        chk("model_an", an, exp_an);
        chk("model_seg", seg, exp_seg);
        chk("model_dp", dp, exp_dp);
        chk("model_go", go_pulse, exp_go);
        chk("model_shown", shown, m_shown);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_an"}, an, 8'hFF);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"}, dp, 1'b1);
        chk({tag, "_go"}, go_pulse, 1'b0);
        chk({tag, "_shown"}, shown, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] got_seg [8];
        logic [7:0] seen;
        logic [6:0] walk_exp [8];
        int pulses, pstep, dp0_fe, dp0_other, hold;

        walk_exp = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        CLR = 1'b1; print_en = 1'b0; print_data = '0; halt = 1'b0; go_btn = 1'b0;

        // Reset held three cycles, then first post-reset display state.
        repeat (3) step();
        chk_reset_values("reset");
        CLR = 1'b0;
        step();
        chk("post_reset_an", an, 8'hFE);
        chk("post_reset_seg", seg, 7'h40);

        // Print and one full scan of all eight digits.
        print_en = 1'b1; print_data = 32'h89AB_CDEF;
        step();
        print_en = 1'b0;
        chk("print_latch", shown, 32'h89AB_CDEF);
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'h01 << d)) begin
                    got_seg[d] = seg;
                    seen[d]    = 1'b1;
                end
            end
        end
        chk("scan_all_digits", seen, 8'hFF);
        for (int d = 0; d < 8; d++) chk($sformatf("scan_digit%0d", d), got_seg[d], walk_exp[d]);

        // Halt dot appears only on digit 0.
        halt = 1'b1;
        step();
        dp0_fe = 0; dp0_other = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (!dp && an == 8'hFE) dp0_fe++;
            if (!dp && an != 8'hFE) dp0_other++;
        end
        chk("halt_dp_digit0", dp0_fe, SCAN_DIV);
        chk("halt_dp_others", dp0_other, 0);
        halt = 1'b0;
        step();
        dp0_fe = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (!dp) dp0_fe++;
        end
        chk("nohalt_dp", dp0_fe, 0);

        // Bouncy press while halted: one pulse, DC+3 steps after the final rise.
        halt = 1'b1;
        repeat (2) step();
        pulses = 0; pstep = -1;
        for (int i = 0; i < 6; i++) begin
            go_btn = (i % 2 == 0);
            repeat (3) begin step(); if (go_pulse) pulses++; end
        end
        go_btn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (go_pulse) begin pulses++; pstep = k; end
        end
        chk("bouncy_pulse_count", pulses, 1);
        chk("bouncy_pulse_latency", pstep, DC + 3);
        go_btn = 1'b0;
        pulses = 0;
        repeat (30) begin step(); if (go_pulse) pulses++; end
        chk("release_no_pulse", pulses, 0);

        // Clean press while running, then halt while held: nothing queued.
        halt = 1'b0; go_btn = 1'b1;
        pulses = 0;
        repeat (20) begin step(); if (go_pulse) pulses++; end
        chk("press_not_halted", pulses, 0);
        halt = 1'b1;
        repeat (20) begin step(); if (go_pulse) pulses++; end
        chk("press_not_queued", pulses, 0);
        go_btn = 1'b0;
        repeat (20) step();

        // Reset mid-scan (digit 3) and mid-debounce (count 5).
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        print_en = 1'b1; print_data = 32'h1234_5678;
        step();
        print_en = 1'b0;
        repeat (7) step();
        go_btn = 1'b1;
        repeat (7) step();
        CLR = 1'b1;
        step();
        chk_reset_values("midreset");
        CLR = 1'b0;
        pulses = 0; pstep = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (go_pulse) begin pulses++; pstep = k; end
        end
        chk("redebounce_count", pulses, 1);
        chk("redebounce_latency", pstep, DC + 3);
        go_btn = 1'b0;
        repeat (20) step();

        // Randomized phase against the model.
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            print_en   = ($urandom_range(7) == 0);
            print_data = $urandom;
            if ($urandom_range(15) == 0) halt = ~halt;
            if (hold == 0) begin
                go_btn = $urandom_range(1);
                hold   = $urandom_range(20, 1);
            end
            hold--;
            CLR = ($urandom_range(199) == 0);
            step();
        end
        CLR = 1'b0; print_en = 1'b0; go_btn = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_console.md
# seg_console

Operator-side end of the syscall print/halt path. Accepts the one-cycle print strobe and 32-bit value produced when the CPU executes a print syscall, and shows the latched value as eight hex digits on a multiplexed active-low seven-segment display, with the decimal point flagging halt. Debounces the raw GO push-button into a single-cycle resume pulse that is returned to the syscall controller only while the CPU is halted.

## Interface
- SCAN_DIV, 100000: clock cycles each digit stays lit (≥2)
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a button level change (≥2)

- CLK  in  1  system clock; single clock domain
- CLR  in  1  reset, synchronous, active-high
- print_en  in  1  one-cycle strobe: print_data valid
- print_data  in  32  value to display
- halt  in  1  CPU halted (level)
- go_btn  in  1  raw, asynchronous, bouncing GO button (active-high)
- go_pulse  out  1  one-cycle debounced resume pulse
- shown  out  32  currently latched display value
- seg  out  7  segment cathodes, active-low, seg[6:0] = g,f,e,d,c,b,a
- an  out  8  digit anodes, active-low, an[0] = rightmost digit
- dp  out  1  decimal point, active-low

## Operation
- Latch: print_en=1 → shown <= print_data at next edge. Without print_en, shown holds. Reset value 0.
- Scan divider: cnt counts 0..SCAN_DIV-1, wraps to 0; on wrap, digit index idx (3 bits) increments mod 8 (7 → 0).
- Output register: each cycle an <= ~(8'b1 << idx), seg <= hex7(shown[4*idx+3 : 4*idx]), dp <= ~(halt && idx==0). Digit 0 shows the least significant nibble.
- hex7 (active-low, g..a): 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Debouncer: go_btn through 2-flop synchronizer → s. Stable state st (reset 0) and counter dc (reset 0). If s==st: dc <= 0. Else dc increments; when dc reaches DEBOUNCE_CYCLES-1, st <= s and dc <= 0. Any bounce back to st before that clears dc.
- go_pulse: 1 for exactly one cycle on the edge after st goes 0→1, only if halt=1 on that cycle; otherwise the press is discarded (no pending/queued pulse). Release (1→0) never pulses.

## Timing
- Reset (CLR=1 at an edge): shown=0, cnt=0, idx=0, st=0, dc=0, sync flops 0, go_pulse=0, an=8'hFF, seg=7'h7F, dp=1. First edge after CLR deasserts: an=8'hFE, seg=7'h40.
- Print latency: print_en at edge N → shown updated at N+1 → seg reflects it at N+2 when the matching digit is active.
- print_en on the same edge as a digit advance: the new digit's first cycle shows the old nibble; new value from next cycle.
- Consecutive print_en strobes: each latches; last wins.
- halt change → dp follows one cycle later (registered).
- Button latency: go_btn stable high from edge N → go_pulse high at edge N+2+DEBOUNCE_CYCLES (±1), one cycle wide.
- CLR mid-scan or mid-debounce: all state returns to reset values immediately; an in-progress press must be re-debounced from zero.

## Structure
- Shared package seg_pkg: hex7 lookup constants (16×7-bit, active-low), digit count 8, SEG_BLANK=7'h7F.
- Sub-module go_debounce (synchronizer + counter + rising-edge detect, parameter DEBOUNCE_CYCLES, outputs st and rise); seg_console gates rise with halt.

## Test plan
- Use SCAN_DIV=4, DEBOUNCE_CYCLES=8 throughout.
- Reset: hold CLR 3 cycles → an=8'hFF, seg=7'h7F, dp=1, go_pulse=0; one cycle after release an=8'hFE, seg=7'h40.
- Print 32'h89AB_CDEF: shown=32'h89ABCDEF next cycle; over one 32-cycle scan, an walks FE,FD,…,7F with seg 0E,06,21,46,03,08,10,00.
- halt=1: dp=0 only while an=8'hFE; halt=0 → dp stays 1.
- Bouncy press while halt=1: toggle go_btn 1/0 every 3 cycles for 20 cycles then hold 1 → exactly one go_pulse, ~10 cycles after final rise; release produces none.
- Clean press while halt=0 → no go_pulse; then set halt=1 while still held → still no pulse (not queued).
- CLR asserted mid-debounce (dc=5) and mid-scan (idx=3) → all reset values next cycle; shown=0.
